// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
package regfile_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StClear,
        StDone
    } clr_state_e;

    localparam int unsigned DefaultWidth = 16;
    localparam int unsigned DefaultDepth = 16;

endpackage

// File: rtl/regfile_2r1w_if.sv
// Write, read and clear-control bundle for regfile_2r1w.
interface regfile_2r1w_if import regfile_pkg::*; #(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned AW    = $clog2(DefaultDepth)
);

    logic             wen;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;
    logic [AW-1:0]    raddr1;
    logic [WIDTH-1:0] rdata1;
    logic [AW-1:0]    raddr2;
    logic [WIDTH-1:0] rdata2;
    logic             clr_req;
    logic             busy;
    logic             clr_done;

    modport master (
        output wen, waddr, wdata, raddr1, raddr2, clr_req,
        input  rdata1, rdata2, busy, clr_done
    );

    modport slave (
        input  wen, waddr, wdata, raddr1, raddr2, clr_req,
        output rdata1, rdata2, busy, clr_done
    );

endinterface

// File: rtl/regfile_row.sv
// One storage row of the register file; write enable and data are muxed by the parent.
module regfile_row #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_2r1w.sv
// WIDTH x DEPTH register file: one synchronous write port, two combinational read ports
// with write bypass, and a one-entry-per-cycle bulk clear engine.
module regfile_2r1w import regfile_pkg::*; #(
    parameter int unsigned WIDTH     = DefaultWidth,
    parameter int unsigned DEPTH     = DefaultDepth,
    parameter bit          ZERO_REG0 = 1'b1
) (
    input logic           clk,
    input logic           rst,
    regfile_2r1w_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    clr_state_e       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             clearing;
    logic             wr_en;
    logic             busy;
    logic             clr_done;
    logic [WIDTH-1:0] row_d;
    logic [DEPTH-1:0] row_we;
    logic [WIDTH-1:0] row_q [DEPTH];
    logic [WIDTH-1:0] rd1, rd2;

    assign clearing = (state_q == StClear);

    // User writes are locked out while clearing, and entry 0 is read-only when hardwired.
    assign wr_en = bus.wen && !clearing && !(ZERO_REG0 && (bus.waddr == '0));
    assign row_d = clearing ? '0 : bus.wdata;

    for (genvar i = 0; i < DEPTH; i++) begin : g_row
        assign row_we[i] = clearing ? (idx_q == AW'(i)) : (wr_en && (bus.waddr == AW'(i)));

        regfile_row #(
            .WIDTH (WIDTH)
        ) u_row (
            .clk (clk),
            .rst (rst),
            .wen (row_we[i]),
            .d   (row_d),
            .q   (row_q[i])
        );
    end

    // Bypass first, then the hardwired zero overrides everything.
    always_comb begin
        rd1 = row_q[bus.raddr1];
        if (wr_en && (bus.waddr == bus.raddr1)) rd1 = bus.wdata;
        if (ZERO_REG0 && (bus.raddr1 == '0)) rd1 = '0;

        rd2 = row_q[bus.raddr2];
        if (wr_en && (bus.waddr == bus.raddr2)) rd2 = bus.wdata;
        if (ZERO_REG0 && (bus.raddr2 == '0)) rd2 = '0;
    end

    assign bus.rdata1   = rd1;
    assign bus.rdata2   = rd2;
    assign bus.busy     = busy;
    assign bus.clr_done = clr_done;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        busy     = 1'b0;
        clr_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.clr_req) begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            end
            StClear: begin
                busy  = 1'b1;
                idx_d = idx_q + 1'b1;
                if (idx_q == AW'(DEPTH - 1)) state_d = StDone;
            end
            StDone: begin
                clr_done = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

endmodule
